t35_gpio_checker: RTL
=====================

# t35_gpio_checker

Receive-side companion to the T35 GPIO counter pattern generator: samples up to NUM_BANKS 8-bit GPIO input banks, acquires the free-running 8-bit incrementing pattern, then checks every bank on every cycle for sequence and inter-bank skew errors. Sits at the far end of a board-to-board or loopback cable. Reports lock state, sticky per-bank error flags, a saturating error count and a pass indication for LEDs or the logic analyser header.

## Interface
- NUM_BANKS, 27: number of 8-bit input banks checked.
- LOCK_MATCHES, 4: consecutive clean cycles needed to declare lock; range 1..15.
- LOSS_MISSES, 4: consecutive erroneous cycles in TRACK that declare loss of lock; range 1..15.

- clk  in  1  system clock, also the clock of the pattern source.
- pll_LOCKED  in  1  reset: synchronous, active-low; the block is held in reset while low.
- gpio_in  in  8*NUM_BANKS  input banks; bank b occupies [8b+7:8b]; bank 0 is the reference bank.
- clear  in  1  synchronous pulse; clears bank_err, err_count and lost.
- state  out  2  FSM state: IDLE=0, ACQUIRE=1, TRACK=2, LOST=3.
- locked  out  1  high while state==TRACK.
- bank_err  out  NUM_BANKS  sticky per-bank error flags.
- err_count  out  16  erroneous TRACK cycles; saturates at 16'hFFFF.
- lost  out  1  sticky; set on every TRACK->LOST transition.
- sample  out  8  last captured bank 0 value.
- pass  out  1  locked & ~|bank_err & ~lost.

## Operation
- Capture stage registers gpio_in. Compare logic uses the captured value cap[b] and a registered expected value exp.
- Per cycle: seq_err = (cap[0] != exp). skew_err[b] = (cap[b] != cap[0]) for b>0. Failing-bank vector: bit 0 = seq_err, bit b = skew_err[b]. any_err = OR of the vector.
- IDLE: entered on reset. Moves to ACQUIRE on the first cycle out of reset.
- ACQUIRE: exp <= cap[0]+1 (mod 256) every cycle. The match counter increments when all banks equal cap[0] and cap[0] equals the previous exp; otherwise it returns to 0. The match in the first ACQUIRE cycle is not counted. When the match counter reaches LOCK_MATCHES, go to TRACK. No error recording in this state.
- TRACK: exp <= exp+1 every cycle, independent of the input. A single-cycle glitch therefore costs exactly one error cycle, and the 8'hFF->8'h00 wrap is not an error. On any_err: OR the vector into bank_err, increment err_count (saturating), and increment the miss counter. On a clean cycle the miss counter returns to 0. When the miss counter reaches LOSS_MISSES, go to LOST.
- LOST: sets lost and moves to ACQUIRE on the next cycle. The match and miss counters are cleared.
- clear takes effect on the same edge. If an error is detected in the same cycle as clear, it is still recorded: err_count=1 and the vector is written into bank_err.
- A pattern restart (the generator's reset value 8'hFF followed by 8'h00) during TRACK is treated as ordinary errors until lock is lost and reacquired.

## Timing
- Reset values: state=IDLE, locked=0, bank_err=0, err_count=0, lost=0, sample=8'h00, pass=0, exp=8'h00, all internal counters 0.
- Latency from gpio_in to cap: 1 cycle, or 2 with the macro below.
- Latency from cap to bank_err/err_count/state update: 1 cycle.
- Minimum time from reset release to locked, with a clean pattern: 1 (IDLE) + 1 (seed) + LOCK_MATCHES cycles after the first valid capture.
- pll_LOCKED low at any time, including mid-TRACK: every register returns to its reset value on the next edge.

## Configuration
- T35_GPIO_CHK_SYNC_EN defined: each input bit passes through a two-flop synchronizer before capture. Capture latency is 2 cycles; use this for cables from an asynchronous source.
- Not defined: single capture register, latency 1 cycle.
- Checking behaviour is otherwise identical in both builds.

## Structure
- Package t35_gpio_chk_pkg holds:
  - the state encoding constants (IDLE, ACQUIRE, TRACK, LOST);
  - BANK_W=8;
  - ERRCNT_W=16;
  - the saturation constant.
- Sub-module t35_gpio_chk_capture holds the input register or synchronizer, selected by T35_GPIO_CHK_SYNC_EN, for all banks. Compare logic, FSM and counters stay in the top module.

## Test plan
- Reset, then drive all banks with the pattern FF,00,01,... -> state reaches TRACK after LOCK_MATCHES+2 captured cycles; after 600 cycles (wraps included), err_count=0 and pass=1.
- In TRACK, flip bit 3 of bank 5 for one cycle -> bank_err=1<<5, err_count=1, state stays TRACK, pass=0.
- In TRACK, hold bank 0 stuck for one cycle, then resume the correct sequence -> bank_err[0]=1 and the other banks flagged skew for that cycle, err_count=1, no loss of lock.
- Freeze all banks at 8'h40 for 4 cycles -> err_count=4, state goes TRACK->LOST->ACQUIRE, lost=1; resume the pattern -> TRACK again with lost still 1.
- Assert clear in the same cycle as a bank 2 error after err_count=7 -> err_count=1, bank_err=1<<2, lost=0.
- Drop pll_LOCKED for one cycle mid-TRACK -> next edge shows state=IDLE and all outputs at their reset values; lock is reacquired afterwards.

Source files
------------

// File: rtl/t35_gpio_checker_pkg.sv
// Shared constants and state encoding for the T35 GPIO pattern checker.
// Optional build macro: T35_GPIO_CHK_SYNC_EN (see t35_gpio_chk_capture).
package t35_gpio_chk_pkg;
  localparam int BANK_W   = 8;
  localparam int ERRCNT_W = 16;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOST    = 2'd3
  } chk_state_e;
endpackage

// File: rtl/t35_gpio_checker_if.sv
// Bus between the GPIO checker and its user: input banks, clear pulse, status.
interface t35_gpio_checker_if #(parameter int NUM_BANKS = 27) ();
  import t35_gpio_chk_pkg::*;

  logic [NUM_BANKS-1:0][BANK_W-1:0] gpio_in;
  logic                             clear;
  logic [1:0]                       state;
  logic                             locked;
  logic [NUM_BANKS-1:0]             bank_err;
  logic [ERRCNT_W-1:0]              err_count;
  logic                             lost;
  logic [BANK_W-1:0]                sample;
  logic                             pass;

  modport master (output gpio_in, clear,
                  input  state, locked, bank_err, err_count, lost, sample, pass);
  modport slave  (input  gpio_in, clear,
                  output state, locked, bank_err, err_count, lost, sample, pass);
endinterface

// File: rtl/t35_gpio_checker_capture.sv
// Per-bank input capture: one register, or a two-flop synchronizer when
// T35_GPIO_CHK_SYNC_EN is defined (for cables from an asynchronous source).
module t35_gpio_chk_capture #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
`ifdef T35_GPIO_CHK_SYNC_EN
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
`else
  logic [W-1:0] r_cap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_cap <= '0;
    else          r_cap <= i_d;
  end

  assign o_q = r_cap;
`endif
endmodule

// File: rtl/t35_gpio_checker.sv
// Receive-side checker for the T35 incrementing GPIO pattern: acquire, track,
// flag sequence/skew errors per bank. Capture depth set by T35_GPIO_CHK_SYNC_EN.
module t35_gpio_checker
  import t35_gpio_chk_pkg::*;
#(
  parameter int NUM_BANKS    = 27,
  parameter int LOCK_MATCHES = 4,
  parameter int LOSS_MISSES  = 4
) (
  input  logic               clk,
  input  logic               pll_LOCKED,
  t35_gpio_checker_if.slave  bus
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_MATCHES);
  localparam logic [3:0] LOSS_N = 4'(LOSS_MISSES);

  logic [NUM_BANKS-1:0][BANK_W-1:0] w_cap;
  logic [NUM_BANKS-1:0]             w_fail;
  logic                             w_any;
  logic                             w_rec;
  logic [3:0]                       w_match_nxt;
  logic [3:0]                       w_miss_nxt;

  chk_state_e          r_state;
  logic [BANK_W-1:0]   r_exp;
  logic [3:0]          r_match;
  logic [3:0]          r_miss;
  logic                r_seeded;
  logic [NUM_BANKS-1:0] r_bank_err;
  logic [ERRCNT_W-1:0] r_err_cnt;
  logic                r_lost;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_cap
    t35_gpio_chk_capture #(.W(BANK_W)) u_cap (
      .i_clk   (clk),
      .i_rst_n (pll_LOCKED),
      .i_d     (bus.gpio_in[b]),
      .o_q     (w_cap[b])
    );
  end

  // Bit 0 is the sequence check on the reference bank; the rest are skew vs bank 0.
  always_comb begin
    w_fail    = '0;
    w_fail[0] = (w_cap[0] != r_exp);
    for (int b = 1; b < NUM_BANKS; b++) w_fail[b] = (w_cap[b] != w_cap[0]);
  end

  assign w_any       = |w_fail;
  assign w_rec       = (r_state == TRACK) && w_any;
  assign w_match_nxt = r_match + 4'd1;
  assign w_miss_nxt  = r_miss + 4'd1;

  always_ff @(posedge clk) begin
    if (!pll_LOCKED) begin
      r_state    <= IDLE;
      r_exp      <= '0;
      r_match    <= '0;
      r_miss     <= '0;
      r_seeded   <= 1'b0;
      r_bank_err <= '0;
      r_err_cnt  <= '0;
      r_lost     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state  <= ACQUIRE;
          r_seeded <= 1'b0;
        end
        ACQUIRE: begin
          // First ACQUIRE cycle only seeds exp; its comparison is meaningless.
          r_exp    <= w_cap[0] + 8'd1;
          r_seeded <= 1'b1;
          if (r_seeded && !w_any) begin
            r_match <= w_match_nxt;
            if (w_match_nxt == LOCK_N) begin
              r_state <= TRACK;
              r_match <= '0;
              r_miss  <= '0;
            end
          end else begin
            r_match <= '0;
          end
        end
        TRACK: begin
          r_exp <= r_exp + 8'd1;
          if (w_any) begin
            r_miss <= w_miss_nxt;
            if (w_miss_nxt == LOSS_N) r_state <= LOST;
          end else begin
            r_miss <= '0;
          end
        end
        default: begin
          r_state  <= ACQUIRE;
          r_match  <= '0;
          r_miss   <= '0;
          r_seeded <= 1'b0;
        end
      endcase

      // An error coincident with clear is still recorded as the first one.
      if (bus.clear) begin
        r_bank_err <= w_rec ? w_fail : '0;
        r_err_cnt  <= w_rec ? ERRCNT_W'(1) : '0;
        r_lost     <= 1'b0;
      end else if (w_rec) begin
        r_bank_err <= r_bank_err | w_fail;
        r_err_cnt  <= (r_err_cnt == ERRCNT_MAX) ? r_err_cnt : r_err_cnt + ERRCNT_W'(1);
      end
      if (w_rec && (w_miss_nxt == LOSS_N)) r_lost <= 1'b1;
    end
  end

  assign bus.state     = r_state;
  assign bus.locked    = (r_state == TRACK);
  assign bus.bank_err  = r_bank_err;
  assign bus.err_count = r_err_cnt;
  assign bus.lost      = r_lost;
  assign bus.sample    = w_cap[0];
  assign bus.pass      = (r_state == TRACK) && !(|r_bank_err) && !r_lost;
endmodule
